// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the divider and multiplier blocks.
package divider_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Width of a counter that walks 0 .. w-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One radix-2 restoring step: trial-subtract the divisor from the shifted
// partial remainder and shift the resulting quotient bit into Q.
module restoring_div_step
    import divider_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH:0]   p_i,
    input  logic [DATA_WIDTH-1:0] q_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH:0]   p_o,
    output logic [DATA_WIDTH-1:0] q_o
);

    localparam int unsigned TW = DATA_WIDTH + 2;

    logic [TW-1:0] trial;
    logic          neg;

    // Trial difference; its sign bit decides restore versus keep.
    always_comb begin
        trial = {p_i, q_i[DATA_WIDTH-1]} - {2'b00, d_i};
        neg   = trial[TW-1];
        p_o   = neg ? {p_i[DATA_WIDTH-1:0], q_i[DATA_WIDTH-1]} : trial[DATA_WIDTH:0];
        q_o   = {q_i[DATA_WIDTH-2:0], ~neg};
    end

endmodule

// File: rtl/restoring_divider_seq.sv
// Sequential radix-2 restoring unsigned divider, one quotient bit per clock,
// valid/ready on both sides. Define DIV_REMAINDER_OUT_EN to expose the
// remainder port; without it the quotient path and timing are unchanged.
module restoring_divider_seq
    import divider_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
`ifdef DIV_REMAINDER_OUT_EN
    output logic [DATA_WIDTH-1:0] remainder,
`endif
    output logic                  div_by_zero
);

    localparam int unsigned   CW       = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

    div_state_t            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH:0]   p_q, p_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic [DATA_WIDTH-1:0] quot_q, quot_d;
`ifdef DIV_REMAINDER_OUT_EN
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
`endif
    logic                  dbz_q, dbz_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;

    logic [DATA_WIDTH:0]   step_p_c;
    logic [DATA_WIDTH-1:0] step_q_c;
    logic                  accept_c;
    logic                  handoff_c;

    restoring_div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .p_i (p_q),
        .q_i (q_q),
        .d_i (d_q),
        .p_o (step_p_c),
        .q_o (step_q_c)
    );

    assign accept_c  = in_valid && in_ready_q && (state_q == IDLE);
    assign handoff_c = out_valid_q && out_ready;

    // Next-state, datapath and registered-handshake computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        q_d      = q_q;
        d_d      = d_q;
        quot_d   = quot_q;
`ifdef DIV_REMAINDER_OUT_EN
        rem_d    = rem_q;
`endif
        dbz_d    = dbz_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    p_d   = '0;
                    q_d   = dividend;
                    d_d   = divisor;
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        // Zero divisor skips iteration and reports a saturated quotient.
                        state_d = DONE;
                        quot_d  = '1;
`ifdef DIV_REMAINDER_OUT_EN
                        rem_d   = dividend;
`endif
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                p_d   = step_p_c;
                q_d   = step_q_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    quot_d  = step_q_c;
`ifdef DIV_REMAINDER_OUT_EN
                    rem_d   = step_p_c[DATA_WIDTH-1:0];
`endif
                end
            end
            DONE: begin
                if (handoff_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // in_ready follows the state being entered, so a handoff cycle never accepts.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_q == DONE) && !handoff_c;
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            quot_q      <= '0;
`ifdef DIV_REMAINDER_OUT_EN
            rem_q       <= '0;
`endif
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            q_q         <= q_d;
            d_q         <= d_d;
            quot_q      <= quot_d;
`ifdef DIV_REMAINDER_OUT_EN
            rem_q       <= rem_d;
`endif
            dbz_q       <= dbz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quot_q;
`ifdef DIV_REMAINDER_OUT_EN
    assign remainder   = rem_q;
`endif
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Directed bench for restoring_divider_seq (DATA_WIDTH 16). Remainder checks
// are compiled in only when DIV_REMAINDER_OUT_EN is defined.
module tb_restoring_divider_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
`ifdef DIV_REMAINDER_OUT_EN
    logic [15:0] remainder;
`endif
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    restoring_divider_seq #(
        .DATA_WIDTH (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
`ifdef DIV_REMAINDER_OUT_EN
        .remainder   (remainder),
`endif
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, check latency/result, optionally stall the consumer.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                          input int elat, input int stall);
        int w;
        int lat;
        bit seen;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        dividend  = ~a;
        divisor   = b ^ 16'h5A5A;
        chk({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) seen = 1'b1;
        end
        if (elat > 0) chk({tag, "_latency"}, 32'(lat), 32'(elat));
        else          chk({tag, "_seen"}, 32'(seen), 32'd1);
        chk({tag, "_quot"}, 32'(quotient), 32'(eq));
`ifdef DIV_REMAINDER_OUT_EN
        chk({tag, "_rem"}, 32'(remainder), 32'(er));
`endif
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_quot"}, 32'(quotient), 32'(eq));
`ifdef DIV_REMAINDER_OUT_EN
            chk({tag, "_hold_rem"}, 32'(remainder), 32'(er));
`endif
            chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_released"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] rq;
        logic [15:0] rr;
        bit          seen;

        reset     = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;

        // Reset values, and in_ready rising one clock after release.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quot", 32'(quotient), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
`ifdef DIV_REMAINDER_OUT_EN
        chk("rst_rem", 32'(remainder), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors.
        run_op("d100_7",   16'd100,   16'd7,  16'd14,    16'd2, 1'b0, 17, 0);
        run_op("d5_0",     16'd5,     16'd0,  16'hFFFF,  16'd5, 1'b1, 1,  0);
        run_op("d65535_1", 16'hFFFF,  16'd1,  16'hFFFF,  16'd0, 1'b0, 17, 0);
        run_op("d3_10",    16'd3,     16'd10, 16'd0,     16'd3, 1'b0, 17, 0);
        run_op("d7_7",     16'd7,     16'd7,  16'd1,     16'd0, 1'b0, 17, 0);
        run_op("d1000_9",  16'd1000,  16'd9,  16'd111,   16'd1, 1'b0, 17, 20);
        run_op("d0_0",     16'd0,     16'd0,  16'hFFFF,  16'd0, 1'b1, 1,  3);
        run_op("d40000_200", 16'd40000, 16'd200, 16'd200, 16'd0, 1'b0, 17, 0);

        // Reset during BUSY discards the operation.
        in_valid = 1'b1;
        dividend = 16'd500;
        divisor  = 16'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_quot", 32'(quotient), 32'd0);
        chk("mid_rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("mid_rst_no_result", 32'(seen), 32'd0);
        chk("mid_rst_quot_after", 32'(quotient), 32'd0);
        run_op("d500_3", 16'd500, 16'd3, 16'd166, 16'd2, 1'b0, 17, 0);

        // Random operand pairs against a reference arithmetic model.
        for (int n = 0; n < 200; n++) begin
            ra = 16'($urandom);
            rb = (n % 17 == 0) ? 16'd0 : 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            if (rb == 16'd0) begin
                rq = 16'hFFFF;
                rr = ra;
            end else begin
                rq = ra / rb;
                rr = ra % rb;
            end
            run_op("rand", ra, rb, rq, rr, (rb == 16'd0), (rb == 16'd0) ? 1 : 17, n % 5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
